// File: rtl/clock_period_meter.sv
// Measures the period and high time of an asynchronous clock-like signal in
// local-clock cycles and flags periods outside programmable bounds.
module clock_period_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  input  logic [CNT_W-1:0] min_period,
  input  logic [CNT_W-1:0] max_period,
  input  logic             clear,
  output logic             period_valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             too_short,
  output logic             too_long
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       hcnt;
  logic [CNT_W-1:0]       cnt_inc;
  logic [CNT_W-1:0]       hcnt_inc;
  logic                   short_hit;
  logic                   long_hit;

  assign s    = sync[SYNC_STAGES-1];
  assign rise = s & ~s_d;

  // Counters stop at all-ones so an overlong period reads as saturated, never wrapped.
  assign cnt_inc  = (cnt  == CNT_MAX) ? cnt  : cnt  + CNT_ONE;
  assign hcnt_inc = (hcnt == CNT_MAX) ? hcnt : hcnt + CNT_ONE;

  assign short_hit = enable && (state == MEASURE) && rise &&
                     (min_period != '0) && (cnt < min_period);
  assign long_hit  = (state == MEASURE) && (max_period != '0) && (cnt > max_period);

  // Synchronizer and edge register run regardless of enable so re-arming sees clean edges.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync <= '0;
      s_d  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge value,
      // which is what makes this a shift chain rather than a single wire.
      sync <= {sync[SYNC_STAGES-2:0], sig_in};
      s_d  <= s;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      hcnt         <= '0;
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
      too_short    <= 1'b0;
      too_long     <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      // A new violation in the same cycle as clear keeps the flag set.
      too_short    <= short_hit | (too_short & ~clear);
      too_long     <= long_hit  | (too_long  & ~clear);

      if (!enable) begin
        state <= IDLE;
        cnt   <= '0;
        hcnt  <= '0;
      end else begin
        case (state)
          IDLE: state <= ARM;
          ARM: begin
            if (rise) begin
              cnt   <= CNT_ONE;
              hcnt  <= CNT_ONE;
              state <= MEASURE;
            end
          end
          MEASURE: begin
            if (rise) begin
              period       <= cnt;
              high_time    <= hcnt;
              period_valid <= 1'b1;
              cnt          <= CNT_ONE;
              hcnt         <= CNT_ONE;
            end else begin
              cnt <= cnt_inc;
              if (s) hcnt <= hcnt_inc;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clock_period_meter.sv
// Randomized self-checking bench for clock_period_meter; expectations come from
// a waveform-level model of rise-to-rise intervals and enable windows.
module tb_clock_period_meter;

  localparam int SYNC = 2;
  localparam int W    = 16;
  localparam int WS   = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          sig_in = 1'b0;
  logic          clear = 1'b0;
  logic [W-1:0]  min_period = '0;
  logic [W-1:0]  max_period = '0;
  logic [WS-1:0] min_small = '0;
  logic [WS-1:0] max_small = '0;

  logic          period_valid, too_short, too_long;
  logic [W-1:0]  period, high_time;
  logic          period_valid_s, too_short_s, too_long_s;
  logic [WS-1:0] period_s, high_time_s;

  typedef struct {
    int at;
    int per;
    int hi;
  } rep_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  rep_t got[$];
  rep_t got_s[$];
  rep_t expq[$];
  rep_t mr;
  rep_t mrs;
  bit   wave[$];
  bit   en_mask[$];
  int   wedge[$];
  int   clear_at = -1;
  bit   ts_hist[int];
  bit   tl_hist[int];
  bit   exp_short;
  bit   exp_long;

  clock_period_meter #(.CNT_W(W), .SYNC_STAGES(SYNC)) dut (
    .clock(clock), .reset(reset), .enable(enable), .sig_in(sig_in),
    .min_period(min_period), .max_period(max_period), .clear(clear),
    .period_valid(period_valid), .period(period), .high_time(high_time),
    .too_short(too_short), .too_long(too_long)
  );

  clock_period_meter #(.CNT_W(WS), .SYNC_STAGES(SYNC)) dut_small (
    .clock(clock), .reset(reset), .enable(enable), .sig_in(sig_in),
    .min_period(min_small), .max_period(max_small), .clear(clear),
    .period_valid(period_valid_s), .period(period_s), .high_time(high_time_s),
    .too_short(too_short_s), .too_long(too_long_s)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Observe outputs half a cycle after each active edge; cyc names that edge.
  always @(negedge clock) begin
    ts_hist[cyc] = too_short;
    tl_hist[cyc] = too_long;
    if (period_valid === 1'b1) begin
      mr.at = cyc; mr.per = int'(period); mr.hi = int'(high_time);
      got.push_back(mr);
    end
    if (period_valid_s === 1'b1) begin
      mrs.at = cyc; mrs.per = int'(period_s); mrs.hi = int'(high_time_s);
      got_s.push_back(mrs);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not reach its end, errors so far %0d", errors);
    $fatal(1);
  end

  function automatic void push_samp(bit v, bit e);
    wave.push_back(v);
    en_mask.push_back(e);
  endfunction

  function automatic void add_periods(int p, int h, int n);
    for (int k = 0; k < n; k++)
      for (int j = 0; j < p; j++) push_samp(j < h, 1'b1);
  endfunction

  function automatic void finish_wave();
    for (int j = 0; j <= SYNC; j++) push_samp(1'b0, 1'b1);
    push_samp(1'b0, 1'b0);
  endfunction

  function automatic int sat(int v, int m);
    return (v > m) ? m : v;
  endfunction

  function automatic bit en_at(int t);
    return (t >= 0 && t < en_mask.size()) ? en_mask[t] : 1'b0;
  endfunction

  // A rise acts SYNC samples after it appears on sig_in. Each acted rise restarts
  // the count, which then runs until the next acted rise or until enable drops.
  // Only an uninterrupted rise-to-rise interval produces a report.
  function automatic void model(int minv, int maxv, int satv);
    int rises[$];
    int ta, dis, b, span, ones;
    expq.delete();
    exp_short = 1'b0;
    exp_long  = 1'b0;
    for (int i = 0; i < wave.size(); i++)
      if (wave[i] && (i == 0 || !wave[i-1])) rises.push_back(i);
    for (int k = 0; k < rises.size(); k++) begin
      ta = rises[k] + SYNC;
      if (!en_at(ta - 1) || !en_at(ta)) continue;
      dis = ta + 1;
      while (en_at(dis)) dis++;
      span = dis - ta;
      if (k + 1 < rises.size() && rises[k+1] + SYNC < dis) begin
        b = rises[k+1];
        span = b - rises[k];
        ones = 0;
        for (int j = rises[k]; j < b; j++) ones += int'(wave[j]);
        expq.push_back('{wedge[b] + SYNC, sat(span, satv), sat(ones, satv)});
        if (minv != 0 && sat(span, satv) < minv) exp_short = 1'b1;
      end
      if (maxv != 0 && sat(span, satv) > maxv) exp_long = 1'b1;
    end
  endfunction

  task automatic prep();
    @(negedge clock); clear = 1'b1;
    @(negedge clock); clear = 1'b0;
    got.delete(); got_s.delete(); wave.delete(); en_mask.delete();
    clear_at = -1;
    for (int j = 0; j < 6; j++) push_samp(1'b0, 1'b1);
  endtask

  task automatic play();
    wedge.delete();
    for (int i = 0; i < wave.size(); i++) begin
      @(negedge clock);
      sig_in = wave[i];
      enable = en_mask[i];
      clear  = (i == clear_at);
      wedge.push_back(cyc + 1);
    end
    @(negedge clock); clear = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (period_valid !== 1'b0 || too_short !== 1'b0 || too_long !== 1'b0) begin
      errors++; $display("FAIL reset_flags: valid %b short %b long %b, expected all 0", period_valid, too_short, too_long);
    end
    checks++;
    if (period !== '0 || high_time !== '0) begin
      errors++; $display("FAIL reset_values: period %0d high %0d, expected 0 0", period, high_time);
    end
    checks++;
    if (period_s !== '0 || period_valid_s !== 1'b0) begin
      errors++; $display("FAIL reset_small: period %0d valid %b, expected 0 0", period_s, period_valid_s);
    end
    reset = 1'b1;
  endtask

  task automatic test_nominal();
    prep(); min_period = 8; max_period = 12;
    add_periods(10, 5, 6); finish_wave();
    play(); model(8, 12, 65535);
    checks++;
    if (got.size() != expq.size()) begin
      errors++; $display("FAIL nominal_count: got %0d reports, expected %0d", got.size(), expq.size());
    end
    for (int k = 0; k < expq.size() && k < got.size(); k++) begin
      checks++;
      if (got[k].at != expq[k].at || got[k].per != expq[k].per || got[k].hi != expq[k].hi) begin
        errors++;
        $display("FAIL nominal_report%0d: got cycle %0d period %0d high %0d, expected cycle %0d period %0d high %0d",
                 k, got[k].at, got[k].per, got[k].hi, expq[k].at, expq[k].per, expq[k].hi);
      end
    end
    checks++;
    if (too_short !== exp_short || too_long !== exp_long) begin
      errors++; $display("FAIL nominal_flags: short %b long %b, expected %b %b", too_short, too_long, exp_short, exp_long);
    end
  endtask

  task automatic test_too_short();
    prep(); min_period = 8; max_period = 12;
    add_periods(5, 2, 5); finish_wave();
    clear_at = 11 + SYNC;
    play(); model(8, 12, 65535);
    checks++;
    if (got.size() != expq.size()) begin
      errors++; $display("FAIL short_count: got %0d reports, expected %0d", got.size(), expq.size());
    end
    for (int k = 0; k < expq.size() && k < got.size(); k++) begin
      checks++;
      if (got[k].at != expq[k].at || got[k].per != expq[k].per || got[k].hi != expq[k].hi) begin
        errors++;
        $display("FAIL short_report%0d: got cycle %0d period %0d high %0d, expected cycle %0d period %0d high %0d",
                 k, got[k].at, got[k].per, got[k].hi, expq[k].at, expq[k].per, expq[k].hi);
      end
    end
    checks++;
    if (ts_hist[wedge[clear_at] - 1] !== 1'b0 || ts_hist[wedge[clear_at]] !== 1'b1) begin
      errors++; $display("FAIL short_set_wins: before %b at %b, expected 0 1",
                         ts_hist[wedge[clear_at] - 1], ts_hist[wedge[clear_at]]);
    end
    checks++;
    if (too_short !== exp_short) begin
      errors++; $display("FAIL short_sticky: got %b expected %b", too_short, exp_short);
    end
    @(negedge clock); clear = 1'b1;
    @(negedge clock); clear = 1'b0;
    checks++;
    if (too_short !== 1'b0) begin
      errors++; $display("FAIL short_clear: got %b expected 0", too_short);
    end
  endtask

  task automatic test_stuck();
    int e;
    prep(); min_period = 0; max_period = 12;
    add_periods(10, 3, 1); add_periods(20, 3, 1); add_periods(10, 3, 1); finish_wave();
    play(); model(0, 12, 65535);
    checks++;
    if (got.size() != expq.size()) begin
      errors++; $display("FAIL stuck_count: got %0d reports, expected %0d", got.size(), expq.size());
    end
    for (int k = 0; k < expq.size() && k < got.size(); k++) begin
      checks++;
      if (got[k].at != expq[k].at || got[k].per != expq[k].per || got[k].hi != expq[k].hi) begin
        errors++;
        $display("FAIL stuck_report%0d: got cycle %0d period %0d high %0d, expected cycle %0d period %0d high %0d",
                 k, got[k].at, got[k].per, got[k].hi, expq[k].at, expq[k].per, expq[k].hi);
      end
    end
    e = wedge[16] + SYNC;
    checks++;
    if (tl_hist[e + 12] !== 1'b0 || tl_hist[e + 13] !== 1'b1) begin
      errors++; $display("FAIL stuck_timing: too_long at cnt13 %b one later %b, expected 0 1",
                         tl_hist[e + 12], tl_hist[e + 13]);
    end
    checks++;
    if (too_long !== exp_long) begin
      errors++; $display("FAIL stuck_flag: got %b expected %b", too_long, exp_long);
    end
  endtask

  task automatic test_saturation();
    prep(); min_period = 0; max_period = 0; min_small = 0; max_small = 10;
    add_periods(20, 17, 4); finish_wave();
    play(); model(0, 10, 15);
    checks++;
    if (got_s.size() != expq.size()) begin
      errors++; $display("FAIL sat_count: got %0d reports, expected %0d", got_s.size(), expq.size());
    end
    for (int k = 0; k < expq.size() && k < got_s.size(); k++) begin
      checks++;
      if (got_s[k].at != expq[k].at || got_s[k].per != expq[k].per || got_s[k].hi != expq[k].hi) begin
        errors++;
        $display("FAIL sat_report%0d: got cycle %0d period %0d high %0d, expected cycle %0d period %0d high %0d",
                 k, got_s[k].at, got_s[k].per, got_s[k].hi, expq[k].at, expq[k].per, expq[k].hi);
      end
    end
    checks++;
    if (too_long_s !== exp_long || too_short_s !== exp_short) begin
      errors++; $display("FAIL sat_flags: long %b short %b, expected %b %b", too_long_s, too_short_s, exp_long, exp_short);
    end
  endtask

  task automatic test_enable_abort();
    prep(); min_period = 8; max_period = 12;
    add_periods(10, 5, 6); finish_wave();
    for (int t = 29; t < 32; t++) en_mask[t] = 1'b0;
    play(); model(8, 12, 65535);
    checks++;
    if (got.size() != expq.size()) begin
      errors++; $display("FAIL abort_count: got %0d reports, expected %0d", got.size(), expq.size());
    end
    for (int k = 0; k < expq.size() && k < got.size(); k++) begin
      checks++;
      if (got[k].at != expq[k].at || got[k].per != expq[k].per || got[k].hi != expq[k].hi) begin
        errors++;
        $display("FAIL abort_report%0d: got cycle %0d period %0d high %0d, expected cycle %0d period %0d high %0d",
                 k, got[k].at, got[k].per, got[k].hi, expq[k].at, expq[k].per, expq[k].hi);
      end
    end
  endtask

  task automatic test_async_reset();
    prep(); min_period = 8; max_period = 12;
    add_periods(5, 2, 3);
    for (int j = 0; j < 20; j++) push_samp(1'b0, 1'b1);
    play();
    checks++;
    if (too_short !== 1'b1 || too_long !== 1'b1 || period !== W'(5)) begin
      errors++; $display("FAIL areset_setup: short %b long %b period %0d, expected 1 1 5", too_short, too_long, period);
    end
    @(posedge clock); #2; reset = 1'b0; #1;
    checks++;
    if ({period_valid, too_short, too_long} !== 3'b000 || period !== '0 || high_time !== '0) begin
      errors++; $display("FAIL areset_immediate: valid %b short %b long %b period %0d high %0d, expected all 0",
                         period_valid, too_short, too_long, period, high_time);
    end
    @(negedge clock); reset = 1'b1;
    prep();
    add_periods(10, 5, 3); finish_wave();
    play(); model(8, 12, 65535);
    checks++;
    if (got.size() != expq.size()) begin
      errors++; $display("FAIL areset_count: got %0d reports, expected %0d", got.size(), expq.size());
    end
    for (int k = 0; k < expq.size() && k < got.size(); k++) begin
      checks++;
      if (got[k].at != expq[k].at || got[k].per != expq[k].per || got[k].hi != expq[k].hi) begin
        errors++;
        $display("FAIL areset_report%0d: got cycle %0d period %0d high %0d, expected cycle %0d period %0d high %0d",
                 k, got[k].at, got[k].per, got[k].hi, expq[k].at, expq[k].per, expq[k].hi);
      end
    end
  endtask

  task automatic test_random();
    int minv, maxv, p, h, st;
    for (int it = 0; it < 3; it++) begin
      prep();
      minv = $urandom_range(0, 12);
      maxv = (it == 0) ? 0 : $urandom_range(8, 20);
      min_period = W'(minv); max_period = W'(maxv);
      for (int n = 0; n < 8; n++) begin
        p = $urandom_range(3, 14);
        h = $urandom_range(1, p - 1);
        add_periods(p, h, 1);
      end
      finish_wave();
      if (it == 2) begin
        st = $urandom_range(8, 30);
        for (int t = st; t < st + 3; t++) en_mask[t] = 1'b0;
      end
      play(); model(minv, maxv, 65535);
      checks++;
      if (got.size() != expq.size()) begin
        errors++; $display("FAIL random%0d_count: got %0d reports, expected %0d", it, got.size(), expq.size());
      end
      for (int k = 0; k < expq.size() && k < got.size(); k++) begin
        checks++;
        if (got[k].at != expq[k].at || got[k].per != expq[k].per || got[k].hi != expq[k].hi) begin
          errors++;
          $display("FAIL random%0d_report%0d: got cycle %0d period %0d high %0d, expected cycle %0d period %0d high %0d",
                   it, k, got[k].at, got[k].per, got[k].hi, expq[k].at, expq[k].per, expq[k].hi);
        end
      end
      checks++;
      if (too_short !== exp_short || too_long !== exp_long) begin
        errors++; $display("FAIL random%0d_flags: short %b long %b, expected %b %b (min %0d max %0d)",
                           it, too_short, too_long, exp_short, exp_long, minv, maxv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_too_short();
    test_stuck();
    test_saturation();
    test_enable_abort();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
